// File: rtl/vtiming_pkg.sv
// vtiming_pkg: shared types and HVGEN nominal geometry for the video timing decoder
package vtiming_pkg;
  localparam int CW_DEF = 10;
  localparam int H_ACTIVE = 289;
  localparam int H_TOTAL = 384;
  localparam int HS_W = 31;
  localparam int V_ACTIVE = 224;
  localparam int V_TOTAL = 263;
  localparam int VS_W = 7;
  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
  typedef struct packed {
    logic [CW_DEF-1:0] h_active;
    logic [CW_DEF-1:0] h_total;
    logic [CW_DEF-1:0] hs_width;
    logic [CW_DEF-1:0] v_active;
    logic [CW_DEF-1:0] v_total;
    logic [CW_DEF-1:0] vs_width;
  } meas_t;
endpackage

// File: rtl/vtiming_axis_counter.sv
// vtiming_axis_counter: saturating total/active/sync counts over the span between restart events
module vtiming_axis_counter #(
  parameter int CW = 10,
  parameter int TIMEOUT = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          step,
  input  logic          restart,
  input  logic          qual,
  input  logic          sync,
  output logic [CW-1:0] total,
  output logic [CW-1:0] active,
  output logic [CW-1:0] sync_w,
  output logic          ovf,
  output logic          tmo
);
  localparam logic [CW-1:0] MAX = '1;
  localparam logic [CW-1:0] NEAR = {{(CW-1){1'b1}}, 1'b0};
  localparam logic [CW-1:0] TO_M1 = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt, act_cnt, syn_cnt, total_q, active_q, sync_q;
  // a restart tick exposes the span just closed so the caller sees it the same clk
  assign total = restart ? cnt : total_q;
  assign active = restart ? act_cnt : active_q;
  assign sync_w = restart ? syn_cnt : sync_q;
  assign ovf = step && !restart && (cnt == NEAR || (qual && act_cnt == NEAR) || (sync && syn_cnt == NEAR));
  assign tmo = TIMEOUT != 0 && step && !restart && cnt == TO_M1;
  always_ff @(posedge clk)
    if (reset) {cnt, act_cnt, syn_cnt, total_q, active_q, sync_q} <= '0;
    else if (restart) begin
      {total_q, active_q, sync_q} <= {cnt, act_cnt, syn_cnt};
      cnt <= CW'(step);
      act_cnt <= CW'(step && qual);
      syn_cnt <= CW'(step && sync);
    end else if (step) begin
      cnt <= cnt + CW'(cnt != MAX);
      act_cnt <= act_cnt + CW'(qual && act_cnt != MAX);
      syn_cnt <= syn_cnt + CW'(sync && syn_cnt != MAX);
    end
endmodule

// File: rtl/vtiming_decoder.sv
// vtiming_decoder: recovers raster position, line/frame geometry and lock from a blank/sync stream
module vtiming_decoder
  import vtiming_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int LOCK_FRAMES = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce_pix,
  input  logic          hblank,
  input  logic          vblank,
  input  logic          hsync,
  input  logic          vsync,
  output logic [CW-1:0] hpos,
  output logic [CW-1:0] vpos,
  output logic          de,
  output logic [CW-1:0] h_active,
  output logic [CW-1:0] h_total,
  output logic [CW-1:0] hs_width,
  output logic [CW-1:0] v_active,
  output logic [CW-1:0] v_total,
  output logic [CW-1:0] vs_width,
  output logic          locked,
  output logic          frame_start,
  output logic          err
);
  localparam int MW = $clog2(LOCK_FRAMES + 1);
  logic hb_q, vb_q, ls, fs, fault, same;
  logic h_ovf, v_ovf, h_tmo, v_tmo;
  logic [CW-1:0] h_tot, h_act, h_syn, v_tot, v_act, v_syn;
  logic [6*CW-1:0] cur;
  logic [MW-1:0] match_cnt;
  state_t state;
  assign ls = ce_pix & hb_q & ~hblank;
  assign fs = ce_pix & vb_q & ~vblank;
  assign fault = h_ovf | v_ovf | h_tmo | v_tmo;
  assign cur = {h_act, h_tot, h_syn, v_act, v_tot, v_syn};
  assign same = cur == {h_active, h_total, hs_width, v_active, v_total, vs_width};
  vtiming_axis_counter #(.CW(CW), .TIMEOUT(TIMEOUT)) u_h (
    .clk(clk), .reset(reset), .step(ce_pix), .restart(ls), .qual(~hblank), .sync(~hsync),
    .total(h_tot), .active(h_act), .sync_w(h_syn), .ovf(h_ovf), .tmo(h_tmo)
  );
  // vertical axis advances one step per line start, restarting on frame start
  vtiming_axis_counter #(.CW(CW), .TIMEOUT(0)) u_v (
    .clk(clk), .reset(reset), .step(ls), .restart(fs), .qual(~vblank), .sync(~vsync),
    .total(v_tot), .active(v_act), .sync_w(v_syn), .ovf(v_ovf), .tmo(v_tmo)
  );
  always_ff @(posedge clk)
    if (reset) begin
      {hb_q, vb_q} <= 2'b11;
      {hpos, vpos, de} <= '0;
      {h_active, h_total, hs_width, v_active, v_total, vs_width} <= '0;
      state <= SEARCH;
      match_cnt <= '0;
      {locked, frame_start, err} <= '0;
    end else begin
      frame_start <= fs;
      err <= fault | (fs && state == LOCKED && !same);
      if (ce_pix) begin
        {hb_q, vb_q} <= {hblank, vblank};
        hpos <= ls ? '0 : hpos + CW'(hpos != '1);
        vpos <= fs ? '0 : vpos + CW'(ls && vpos != '1);
        de <= ~hblank & ~vblank;
      end
      if (fault) begin
        state <= SEARCH;
        locked <= 1'b0;
      end else if (fs) case (state)
        SEARCH: begin
          state <= MEASURE;
          match_cnt <= '0;
        end
        MEASURE: begin
          {h_active, h_total, hs_width, v_active, v_total, vs_width} <= cur;
          match_cnt <= same ? match_cnt + MW'(1) : '0;
          if (same && match_cnt + MW'(1) >= MW'(LOCK_FRAMES - 1)) begin
            state <= LOCKED;
            locked <= 1'b1;
          end
        end
        default: begin
          {h_active, h_total, hs_width, v_active, v_total, vs_width} <= cur;
          if (!same) begin
            state <= MEASURE;
            locked <= 1'b0;
            match_cnt <= '0;
          end
        end
      endcase
    end
endmodule

// File: tb/tb_vtiming_decoder.sv
// tb_vtiming_decoder: directed scenarios on a compact raster with hand-computed geometry
module tb_vtiming_decoder;
  import vtiming_pkg::*;
  localparam int HT = 48, HA = 36, HS0 = 40, HS1 = 44, VT = 14, VA = 10, VS0 = 11, VS1 = 13;
  localparam meas_t NOM = '{h_active: 10'd36, h_total: 10'd48, hs_width: 10'd4, v_active: 10'd10, v_total: 10'd14, vs_width: 10'd2};
  logic clk = 0, reset = 1, ce_pix = 0, hblank = 1, vblank = 1, hsync = 1, vsync = 1;
  logic [9:0] hpos, vpos, h_active, h_total, hs_width, v_active, v_total, vs_width;
  logic de, locked, frame_start, err;
  int total = 0, bad = 0, gap = 0, err_cnt = 0, fs_cnt = 0, spur = 0, tick_no = 0, err_tick = 0;
  logic fs_lk[64], fs_er[64], fs_de[64];
  logic [9:0] fs_ht[64], fs_vt[64], fs_hp[64], fs_vp[64];
  meas_t m;
  vtiming_decoder dut (
    .clk(clk), .reset(reset), .ce_pix(ce_pix), .hblank(hblank), .vblank(vblank), .hsync(hsync), .vsync(vsync),
    .hpos(hpos), .vpos(vpos), .de(de), .h_active(h_active), .h_total(h_total), .hs_width(hs_width),
    .v_active(v_active), .v_total(v_total), .vs_width(vs_width), .locked(locked), .frame_start(frame_start), .err(err)
  );
  always #5 clk = ~clk;
  task automatic tick(input logic hb, input logic vb, input logic hs, input logic vs);
    {hblank, vblank, hsync, vsync} = {hb, vb, hs, vs};
    ce_pix = 1;
    @(posedge clk); #1;
    ce_pix = 0;
    tick_no++;
    if (err) begin err_cnt++; err_tick = tick_no; end
    if (frame_start) begin
      fs_cnt++;
      if (fs_cnt < 64) begin
        fs_lk[fs_cnt] = locked; fs_er[fs_cnt] = err; fs_de[fs_cnt] = de;
        fs_ht[fs_cnt] = h_total; fs_vt[fs_cnt] = v_total; fs_hp[fs_cnt] = hpos; fs_vp[fs_cnt] = vpos;
      end
    end
    repeat (gap) begin
      @(posedge clk); #1;
      if (err || frame_start) spur++;
    end
  endtask
  task automatic pix(input int x, input int y);
    tick(x >= HA, y >= VA, !(x >= HS0 && x < HS1), !(y >= VS0 && y < VS1));
  endtask
  task automatic line(input int y, input int len);
    for (int x = 0; x < len; x++) pix(x, y);
  endtask
  task automatic frame(input int last_len);
    for (int y = 0; y < VT; y++) line(y, y == VT - 1 ? last_len : HT);
  endtask
  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    total++; if ({hpos, vpos, de} !== '0) begin bad++; $display("FAIL reset_pos: hpos=%0d vpos=%0d de=%0b want 0", hpos, vpos, de); end
    m = {h_active, h_total, hs_width, v_active, v_total, vs_width};
    total++; if (m !== '0) begin bad++; $display("FAIL reset_meas: got %h want 0", m); end
    total++; if ({locked, frame_start, err} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {locked, frame_start, err}); end
    reset = 0;
  endtask
  task automatic test_lock;
    gap = 1;
    repeat (3) frame(HT);
    total++; if (fs_cnt !== 3) begin bad++; $display("FAIL lock_fs_count: got %0d want 3", fs_cnt); end
    total++; if ({fs_lk[1], fs_lk[2], fs_lk[3]} !== 3'b001) begin bad++; $display("FAIL lock_sequence: got %b want 001", {fs_lk[1], fs_lk[2], fs_lk[3]}); end
    total++; if (fs_ht[2] !== 10'd48 || fs_vt[2] !== 10'd14) begin bad++; $display("FAIL lock_second_capture: h_total=%0d v_total=%0d want 48 14", fs_ht[2], fs_vt[2]); end
    m = {h_active, h_total, hs_width, v_active, v_total, vs_width};
    total++; if (m !== NOM) begin bad++; $display("FAIL lock_meas: got %h want %h", m, NOM); end
    total++; if ({fs_hp[3], fs_vp[3], fs_de[3]} !== {20'd0, 1'b1}) begin bad++; $display("FAIL fs_ls_coincide: hpos=%0d vpos=%0d de=%0b want 0 0 1", fs_hp[3], fs_vp[3], fs_de[3]); end
    frame(HT);
    total++; if (fs_lk[4] !== 1'b1) begin bad++; $display("FAIL lock_hold: locked=%0b want 1", fs_lk[4]); end
    total++; if (err_cnt !== 0 || spur !== 0) begin bad++; $display("FAIL lock_no_err: err=%0d idle_pulses=%0d want 0 0", err_cnt, spur); end
    gap = 0;
  endtask
  task automatic test_stretch;
    int base = fs_cnt, e0 = err_cnt;
    frame(HT + 1);
    repeat (3) frame(HT);
    total++; if (fs_er[base+2] !== 1'b1 || fs_lk[base+2] !== 1'b0) begin bad++; $display("FAIL stretch_drop: err=%0b locked=%0b want 1 0", fs_er[base+2], fs_lk[base+2]); end
    total++; if (fs_ht[base+2] !== 10'd49) begin bad++; $display("FAIL stretch_h_total: got %0d want 49", fs_ht[base+2]); end
    total++; if (fs_lk[base+3] !== 1'b0 || fs_er[base+3] !== 1'b0) begin bad++; $display("FAIL stretch_remeasure: locked=%0b err=%0b want 0 0", fs_lk[base+3], fs_er[base+3]); end
    total++; if (fs_lk[base+4] !== 1'b1) begin bad++; $display("FAIL stretch_relock: locked=%0b want 1", fs_lk[base+4]); end
    total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL stretch_err_count: got %0d want 1", err_cnt - e0); end
  endtask
  task automatic test_reset_mid;
    int base;
    for (int y = 0; y < 5; y++) line(y, HT);
    line(5, 21);
    total++; if (hpos !== 10'd20 || vpos !== 10'd5) begin bad++; $display("FAIL mid_position: hpos=%0d vpos=%0d want 20 5", hpos, vpos); end
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    total++; if ({hpos, vpos, de, h_active, h_total, hs_width, v_active, v_total, vs_width, locked, frame_start, err} !== '0) begin
      bad++; $display("FAIL mid_reset_clear: hpos=%0d vpos=%0d h_total=%0d v_total=%0d locked=%0b", hpos, vpos, h_total, v_total, locked);
    end
    base = fs_cnt;
    repeat (3) frame(HT);
    total++; if (fs_cnt - base !== 3 || fs_lk[base+1] !== 1'b0) begin bad++; $display("FAIL mid_first_fs: frames=%0d locked=%0b want 3 0", fs_cnt - base, fs_lk[base+1]); end
    total++; if (fs_lk[base+3] !== 1'b1) begin bad++; $display("FAIL mid_relock: locked=%0b want 1", fs_lk[base+3]); end
  endtask
  task automatic test_timeout;
    int base = fs_cnt, e0 = err_cnt, ls_no;
    for (int y = 0; y < 3; y++) line(y, HT);
    pix(0, 3);
    ls_no = tick_no;
    for (int x = 1; x < HA; x++) pix(x, 3);
    repeat (1100) tick(1, 0, 1, 1);
    total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL timeout_err_count: got %0d want 1", err_cnt - e0); end
    total++; if (err_tick - ls_no !== 1022) begin bad++; $display("FAIL timeout_err_tick: got %0d want 1022", err_tick - ls_no); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL timeout_locked: got %0b want 0", locked); end
    m = {h_active, h_total, hs_width, v_active, v_total, vs_width};
    total++; if (m !== NOM) begin bad++; $display("FAIL timeout_meas_hold: got %h want %h", m, NOM); end
    for (int y = 4; y < VT; y++) line(y, HT);
    repeat (2) frame(HT);
    total++; if (fs_lk[base+2] !== 1'b0 || fs_lk[base+3] !== 1'b1) begin bad++; $display("FAIL timeout_relock: got %b want 01", {fs_lk[base+2], fs_lk[base+3]}); end
    total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL timeout_no_extra_err: got %0d want 1", err_cnt - e0); end
  endtask
  task automatic test_ce_hold;
    int base = fs_cnt, e0 = err_cnt, pulses = 0;
    line(0, HT);
    line(1, HT);
    line(2, 10);
    total++; if (hpos !== 10'd9 || vpos !== 10'd2 || de !== 1'b1) begin bad++; $display("FAIL hold_pre: hpos=%0d vpos=%0d de=%0b want 9 2 1", hpos, vpos, de); end
    for (int i = 0; i < 500; i++) begin
      {hblank, vblank, hsync, vsync} = 4'(i);
      @(posedge clk); #1;
      if (err || frame_start) pulses++;
    end
    total++; if (hpos !== 10'd9 || vpos !== 10'd2 || de !== 1'b1) begin bad++; $display("FAIL hold_pos: hpos=%0d vpos=%0d de=%0b want 9 2 1", hpos, vpos, de); end
    total++; if (pulses !== 0 || locked !== 1'b1) begin bad++; $display("FAIL hold_pulses: pulses=%0d locked=%0b want 0 1", pulses, locked); end
    for (int x = 10; x < HT; x++) pix(x, 2);
    for (int y = 3; y < VT; y++) line(y, HT);
    frame(HT);
    total++; if (fs_cnt - base !== 2 || fs_lk[base+2] !== 1'b1 || err_cnt !== e0) begin bad++; $display("FAIL hold_after: frames=%0d locked=%0b errs=%0d", fs_cnt - base, fs_lk[base+2], err_cnt - e0); end
    m = {h_active, h_total, hs_width, v_active, v_total, vs_width};
    total++; if (m !== NOM) begin bad++; $display("FAIL hold_meas: got %h want %h", m, NOM); end
  endtask
  initial begin
    test_reset;
    test_lock;
    test_stretch;
    test_reset_mid;
    test_timeout;
    test_ce_hold;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
